// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding uart_tx one byte per frame, paced by an internal frame timer.
// Optional occupancy port `level` is enabled by defining UART_TXQ_LEVEL_EN.
module uart_tx_queue #(
  parameter int FREQ     = 200,
  parameter int BAUD     = 25,
  parameter int DEPTH    = 8,
  parameter int GAP_BITS = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_enable,
`ifdef UART_TXQ_LEVEL_EN
  output logic [$clog2(DEPTH):0]   level,
`endif
  output logic                     busy
);

  localparam int AW           = $clog2(DEPTH);
  localparam int PW           = AW + 1;
  localparam int CLKS_PER_BIT = FREQ / BAUD;
  localparam int FRAME_CYCLES = CLKS_PER_BIT * (10 + GAP_BITS);
  localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);

  generate
    if (CLKS_PER_BIT < 1) begin : g_bad_baud
      $error("uart_tx_queue: FREQ/BAUD must be at least 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_queue: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  logic [7:0]       mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       tx_data_reg;
  logic             tx_enable_reg;
  state_t           state_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign wr_ready = !full && !rst;
  assign push     = wr_valid && wr_ready;
  // A byte leaves the FIFO only when the line is free: from IDLE, or as the frame timer expires.
  assign pop      = !empty && ((state_reg == IDLE) ||
                               ((state_reg == WAIT) && (cnt_reg == '0)));

  assign tx_data   = tx_data_reg;
  assign tx_enable = tx_enable_reg;
  assign busy      = (state_reg != IDLE) || !empty;

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      cnt_reg       <= '0;
      tx_data_reg   <= 8'h00;
      tx_enable_reg <= 1'b0;
    end else begin
      tx_enable_reg <= 1'b0;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg    <= rd_ptr_reg + PW'(1);
        tx_data_reg   <= mem[rd_ptr_reg[AW-1:0]];
        tx_enable_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (pop) begin
            state_reg <= SEND;
          end
        end
        SEND: begin
          // SEND plus the final WAIT cycle at zero make up the remaining two cycles of the frame.
          cnt_reg   <= CNT_W'(FRAME_CYCLES - 2);
          state_reg <= WAIT;
        end
        WAIT: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else if (pop) begin
            state_reg <= SEND;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TXQ_LEVEL_EN
  logic [PW-1:0] level_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level_reg <= level_reg + PW'(1);
        2'b01:   level_reg <= level_reg - PW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign level = level_reg;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: vector table for reset/first byte, scoreboard on every
// tx_enable, hand sequences for burst/full, mid-frame reset, and a GAP_BITS=2 instance.
module tb_uart_tx_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic [7:0] tx_data;
  logic       tx_enable;
  logic       busy;

  logic       rst2 = 1'b1;
  logic       wr_valid2 = 1'b0;
  logic [7:0] wr_data2 = 8'h00;
  logic       wr_ready2;
  logic [7:0] tx_data2;
  logic       tx_enable2;
  logic       busy2;

`ifdef UART_TXQ_LEVEL_EN
  logic [3:0] level;
  logic [3:0] level2;
`endif

  uart_tx_queue #(.FREQ(200), .BAUD(25), .DEPTH(8), .GAP_BITS(0)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .tx_data(tx_data), .tx_enable(tx_enable),
`ifdef UART_TXQ_LEVEL_EN
    .level(level),
`endif
    .busy(busy)
  );

  uart_tx_queue #(.FREQ(200), .BAUD(25), .DEPTH(8), .GAP_BITS(2)) dut_gap (
    .clk(clk), .rst(rst2), .wr_data(wr_data2), .wr_valid(wr_valid2), .wr_ready(wr_ready2),
    .tx_data(tx_data2), .tx_enable(tx_enable2),
`ifdef UART_TXQ_LEVEL_EN
    .level(level2),
`endif
    .busy(busy2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [7:0] sb [$];
  int en_q [$];
  logic prev_en = 1'b0;
  logic accepted = 1'b0;
  logic done2 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every enable pulse must carry the oldest accepted byte.
  always @(negedge clk) begin
    if (tx_enable === 1'b1) begin
      en_q.push_back(cyc);
      check("enable_single_cycle", int'(prev_en), 0);
      check("sb_has_byte_on_enable", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        check("tx_data_order", int'(tx_data), int'(sb.pop_front()));
      end
      $display("tx byte %02h at cycle %0d", tx_data, cyc);
    end
    prev_en <= (tx_enable === 1'b1);
  end

  // Drive one cycle of inputs just after a negedge; return at the following negedge.
  task automatic drive(input logic r, input logic v, input logic [7:0] d);
    rst = r;
    wr_valid = v;
    wr_data = d;
    #1;
    accepted = !r && v && wr_ready;
    if (r) sb.delete();
    else if (accepted) sb.push_back(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int max_cycles);
    int k;
    for (k = 0; k < max_cycles && busy; k++) drive(1'b0, 1'b0, 8'h00);
    check({name, "_drain_done"}, int'(busy), 0);
  endtask

  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic       e_ready;
    logic       e_en;
    logic       e_busy;
    logic [7:0] e_data;
  } vec_t;

  vec_t vt [6];

  initial begin
    int t0;
    int bi;
    int nen;
    int k;
    int max_lvl;

    vt[0] = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[1] = '{1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[3] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'h00};
    vt[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5};
    vt[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5};

    @(negedge clk);

    // Reset and single-byte latency
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].r, vt[i].v, vt[i].d);
      check($sformatf("vec%0d_wr_ready", i), int'(wr_ready), int'(vt[i].e_ready));
      check($sformatf("vec%0d_tx_enable", i), int'(tx_enable), int'(vt[i].e_en));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].e_busy));
      check($sformatf("vec%0d_tx_data", i), int'(tx_data), int'(vt[i].e_data));
`ifdef UART_TXQ_LEVEL_EN
      if (i == 1) check("reset_level", int'(level), 0);
`endif
    end
    t0 = (en_q.size() > 0) ? en_q[$] : 0;
    drain("single", 300);
    check("busy_fall_after_enable", cyc - t0, 80);

    // Burst of nine bytes fills the queue (first byte leaves immediately)
    bi = en_q.size();
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 8'(i + 1));
      check($sformatf("burst%0d_accept", i), int'(accepted), 1);
      check($sformatf("burst%0d_wr_ready", i), int'(wr_ready), int'(i < 8));
    end
`ifdef UART_TXQ_LEVEL_EN
    check("burst_level_full", int'(level), 8);
`endif
    // Hold a write while full: it must land the cycle after the next pop
    max_lvl = 0;
    for (k = 0; k < 200; k++) begin
      drive(1'b0, 1'b1, 8'h55);
`ifdef UART_TXQ_LEVEL_EN
      if (int'(level) > max_lvl) max_lvl = int'(level);
`endif
      if (accepted) break;
    end
    check("full_write_taken", int'(accepted), 1);
    check("refill_after_pop", cyc - en_q[$], 1);
`ifdef UART_TXQ_LEVEL_EN
    check("level_max_while_full", max_lvl, 8);
    check("level_after_refill", int'(level), 8);
`endif
    drain("burst", 1500);
    check("burst_enable_count", en_q.size() - bi, 10);
    for (int j = bi + 1; j < en_q.size(); j++) begin
      check($sformatf("burst_spacing%0d", j - bi), en_q[j] - en_q[j-1], 80);
    end
    check("burst_sb_empty", sb.size(), 0);

    // Reset during WAIT with three bytes still queued
    drive(1'b0, 1'b1, 8'h11);
    drive(1'b0, 1'b1, 8'h22);
    drive(1'b0, 1'b1, 8'h33);
    drive(1'b0, 1'b1, 8'h44);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    check("midreset_tx_enable", int'(tx_enable), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_tx_data", int'(tx_data), 0);
    check("midreset_wr_ready", int'(wr_ready), 0);
`ifdef UART_TXQ_LEVEL_EN
    check("midreset_level", int'(level), 0);
`endif
    drive(1'b0, 1'b0, 8'h00);
    check("postreset_wr_ready", int'(wr_ready), 1);
    nen = en_q.size();
    for (int i = 0; i < 200; i++) drive(1'b0, 1'b0, 8'h00);
    check("no_enable_after_reset", en_q.size(), nen);
    drive(1'b0, 1'b1, 8'h3C);
    check("after_reset_no_early_enable", int'(tx_enable), 0);
    drive(1'b0, 1'b0, 8'h00);
    check("after_reset_enable", int'(tx_enable), 1);
    check("after_reset_data", int'(tx_data), 8'h3C);
    drain("after_reset", 300);

    for (k = 0; k < 2000 && !done2; k++) @(negedge clk);
    check("gap_bench_done", int'(done2), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // GAP_BITS=2 instance: two queued bytes must go out 96 cycles apart
  initial begin
    int e_cyc [$];
    logic [7:0] e_dat [$];
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    wr_valid2 = 1'b1;
    wr_data2 = 8'h5A;
    #1;
    check("gap_ready0", int'(wr_ready2), 1);
    @(negedge clk);
    wr_data2 = 8'hC3;
    #1;
    check("gap_ready1", int'(wr_ready2), 1);
    @(negedge clk);
    wr_valid2 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx_enable2) begin
        e_cyc.push_back(cyc);
        e_dat.push_back(tx_data2);
        $display("gap tx byte %02h at cycle %0d", tx_data2, cyc);
      end
      @(negedge clk);
    end
    check("gap_enable_count", e_cyc.size(), 2);
    if (e_cyc.size() == 2) begin
      check("gap_spacing", e_cyc[1] - e_cyc[0], 96);
      check("gap_byte0", int'(e_dat[0]), 8'h5A);
      check("gap_byte1", int'(e_dat[1]), 8'hC3);
    end
    check("gap_busy_idle", int'(busy2), 0);
`ifdef UART_TXQ_LEVEL_EN
    check("gap_level_idle", int'(level2), 0);
`endif
    done2 = 1'b1;
  end

endmodule
